// File: rtl/i2c_slave_reg.sv
// I2C target answering at SLAVE_ADDR, bridging bus reads/writes onto a 256x8 register port.
// SCL/SDA are oversampled on clk; the pointer auto-increments and persists across transactions.
module i2c_slave_reg #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCL,
    inout  wire        SDA,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK, S_WR, S_WR_ACK,
        S_RD_LOAD, S_RD_FETCH, S_RD, S_RD_ACK, S_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  scl_q, sda_q;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d, re_q, re_d;
    logic        busy_q, busy_d;
    logic        oe_q, oe_d;
    logic        rw_q, rw_d;
    logic        mack_q, mack_d;
    logic        scl_rise, scl_fall, bus_start, bus_stop, rx_state, byte_done;

    // [1:0] synchronize, [2] holds the previous synchronized sample for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], SCL};
            sda_q <= {sda_q[1:0], SDA};
        end
    end

    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    assign bus_start = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
    assign bus_stop  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
    assign rx_state  = (state_q == S_ADDR) || (state_q == S_REG) || (state_q == S_WR);
    assign byte_done = scl_fall && (cnt_q == 4'd8);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            sh_q    <= 8'd0;
            ptr_q   <= 8'd0;
            wdata_q <= 8'd0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            busy_q  <= 1'b0;
            oe_q    <= 1'b0;
            rw_q    <= 1'b0;
            mack_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            ptr_q   <= ptr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            re_q    <= re_d;
            busy_q  <= busy_d;
            oe_q    <= oe_d;
            rw_q    <= rw_d;
            mack_q  <= mack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        ptr_d   = ptr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        busy_d  = busy_q;
        oe_d    = oe_q;
        rw_d    = rw_q;
        mack_d  = mack_q;
        if (bus_stop) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = 4'd0;
        end else if (bus_start) begin
            // busy stays up until the new address is known to miss
            state_d = S_ADDR;
            oe_d    = 1'b0;
            cnt_d   = 4'd0;
        end else begin
            if (rx_state && scl_rise && cnt_q != 4'd8) begin
                sh_d  = {sh_q[6:0], sda_q[1]};
                cnt_d = cnt_q + 4'd1;
            end
            case (state_q)
                S_ADDR: if (byte_done) begin
                    cnt_d = 4'd0;
                    if (sh_q[7:1] == SLAVE_ADDR) begin
                        state_d = S_ADDR_ACK;
                        busy_d  = 1'b1;
                        oe_d    = 1'b1;
                        rw_d    = sh_q[0];
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
                S_ADDR_ACK: if (scl_fall) begin
                    oe_d  = 1'b0;
                    cnt_d = 4'd0;
                    if (rw_q) begin
                        state_d = S_RD_LOAD;
                        re_d    = 1'b1;
                    end else begin
                        state_d = S_REG;
                    end
                end
                S_REG: if (byte_done) begin
                    ptr_d   = sh_q;
                    oe_d    = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = S_REG_ACK;
                end
                S_REG_ACK: if (scl_fall) begin
                    oe_d    = 1'b0;
                    state_d = S_WR;
                end
                S_WR: if (byte_done) begin
                    we_d    = 1'b1;
                    wdata_d = sh_q;
                    oe_d    = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = S_WR_ACK;
                end
                S_WR_ACK: if (scl_fall) begin
                    oe_d    = 1'b0;
                    ptr_d   = ptr_q + 8'd1;
                    state_d = S_WR;
                end
                S_RD_LOAD: state_d = S_RD_FETCH;
                S_RD_FETCH: begin
                    // reg_rdata answers one clk after reg_re; first bit goes out immediately
                    sh_d    = reg_rdata;
                    oe_d    = ~reg_rdata[7];
                    cnt_d   = 4'd0;
                    state_d = S_RD;
                end
                S_RD: if (scl_fall) begin
                    if (cnt_q == 4'd7) begin
                        oe_d    = 1'b0;
                        state_d = S_RD_ACK;
                    end else begin
                        sh_d  = {sh_q[6:0], 1'b0};
                        oe_d  = ~sh_q[6];
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) mack_d = sda_q[1];
                    if (scl_fall) begin
                        if (mack_q) begin
                            state_d = S_WAIT;
                        end else begin
                            ptr_d   = ptr_q + 8'd1;
                            re_d    = 1'b1;
                            state_d = S_RD_LOAD;
                        end
                    end
                end
                S_IDLE, S_WAIT: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign SDA       = oe_q ? 1'b0 : 1'bz;
    assign reg_addr  = ptr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = re_q;
    assign busy      = busy_q;
endmodule

// File: doc/i2c_slave_reg.md
# i2c_slave_reg

I2C responder (target) with a byte-addressed register-file port, the far end of the team's I2C initiator on the same two-wire bus. It oversamples SCL/SDA on the system clock and decodes START, STOP, address, register pointer and data bytes. Writes go to an external 256×8 register space; reads are fetched from it, with pointer auto-increment. It sits between the board-level I2C pins and any memory or CSR block the team exposes to an external master.

## Interface
- SLAVE_ADDR, 7'h50, 7-bit bus address this target answers to.
- clk  input  1  system clock. Must be ≥ 20× SCL frequency.
- rst  input  1  reset, asynchronous, active-high.
- SCL  input  1  bus clock from master. This block never stretches the clock.
- SDA  inout  1  open-drain data line. Driven 0 when sda_oe=1, otherwise 1'bz.
- reg_addr  output  8  register pointer for the current access.
- reg_wdata  output  8  write data, valid while reg_we=1.
- reg_we  output  1  one-cycle write strobe.
- reg_re  output  1  one-cycle read request.
- reg_rdata  input  8  read data, sampled exactly 1 clk after reg_re.
- busy  output  1  high from address match until STOP, or until the next START whose address misses.

## Operation
- Input path: SCL and SDA each pass through a 2-FF synchronizer, then a third register for edge detection. All decoding uses the synchronized values.
- START: synchronized SDA falls while SCL=1. STOP: SDA rises while SCL=1. Both are recognised in every state.
  - START or repeated START → ADDR, bit counter cleared.
  - STOP → IDLE, sda_oe=0.
- Data bits are sampled on the SCL rising edge. SDA is changed only on the clk after a detected SCL falling edge.
- States:
  - IDLE: SDA released; waits for START.
  - ADDR: shift 8 bits MSB first. On the SCL fall after bit 8:
    - if bits[7:1]==SLAVE_ADDR → ADDR_ACK, busy=1;
    - else → IDLE (no ACK).
  - ADDR_ACK: sda_oe=1 until the next SCL fall. Then, if R/W bit=0 → REG; if 1 → RD_LOAD.
  - REG: receive 8 bits into the pointer register → REG_ACK (drive ACK) → WR.
  - WR: receive 8 bits. On the SCL fall after bit 8:
    - reg_we=1 for one clk, with reg_addr=pointer and reg_wdata=byte;
    - → WR_ACK (drive ACK). At the end of ACK, pointer+1 → WR.
  - RD_LOAD: reg_re=1 for one clk. Next clk, load the shift register from reg_rdata → RD.
  - RD: drive sda_oe = ~bit, MSB first, one bit per SCL low phase. After 8 bits, release SDA → RD_ACK.
  - RD_ACK: sample master ACK on the SCL rise.
    - 0 (ACK) → pointer+1, RD_LOAD on the SCL fall.
    - 1 (NACK) → IDLE-wait: SDA released, waiting for STOP/START, busy held.
- Pointer arithmetic is 8-bit modulo: 8'hFF+1 = 8'h00.
- The pointer is retained across transactions, so a read without a preceding REG phase continues from the last pointer.
- reg_we and reg_re are never asserted in the same clk.

## Timing
- Reset values: sda_oe=0 (SDA=z), reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, state=IDLE, pointer=0, bit counter=0.
- Bus-event detection latency: 3 clk after the pin edge.
- reg_we: asserted 1 clk after the 8th data bit's SCL fall is detected.
- reg_re → reg_rdata sample: exactly 1 clk. The first read bit is on SDA ≤ 3 clk after the detected SCL fall.
- ACK drive: asserted within 1 clk of the detected SCL fall, released within 1 clk of the following SCL fall.
- Reset mid-transfer: SDA released immediately (asynchronously), all state cleared. The block ignores the bus until the next START.
- A START that arrives mid-byte aborts that byte; no reg_we is issued for a partial byte.
- A STOP that arrives during WR before bit 8 discards the partial byte.

## Test plan
- Write: START, 0xA0, 0x10, 0x5A, 0xC3, STOP → ACK on all 4 bytes; reg_we at addr 0x10 data 0x5A, then addr 0x11 data 0xC3; busy low after STOP.
- Random read: START, 0xA0, 0x20, repeated START, 0xA1, master ACK, master NACK, STOP (reg_rdata model returns addr^0xFF) → SDA carries 0xDF then 0xDE; exactly 2 reg_re pulses, at addr 0x20 and 0x21.
- Address miss: START, 0xA2, byte → SDA stays released, no strobes, busy=0.
- Pointer wrap: write pointer 0xFF, then 2 data bytes → reg_we at 0xFF then 0x00.
- Abort: assert rst during bit 4 of a data byte → SDA=z that clk, no reg_we. Afterwards a full transaction succeeds normally.
- Current-address read: after the wrap test, START, 0xA1, NACK, STOP → reg_re at 0x01, one byte returned.
